// File: rtl/fetch_queue.sv
// Instruction buffer between fetch and decode: a DEPTH-entry {pc, instr} FIFO
// with a single-cycle flush for branch redirects and no empty-queue bypass.
module fetch_queue #(
    parameter int DEPTH   = 4,
    parameter int PC_W    = 8,
    parameter int INSTR_W = 8
) (
    input  logic                     clk,
    input  logic                     n_rst,
    input  logic                     flush,
    input  logic                     enq_valid,
    input  logic [PC_W-1:0]          enq_pc,
    input  logic [INSTR_W-1:0]       enq_instr,
    output logic                     enq_ready,
    output logic                     deq_valid,
    output logic [PC_W-1:0]          deq_pc,
    output logic [INSTR_W-1:0]       deq_instr,
    input  logic                     deq_ready,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam int ENT_W = PC_W + INSTR_W;

    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic [ENT_W-1:0] storage [DEPTH];
    logic             enq_fire;
    logic             deq_fire;

    // A full queue refuses enq even if the head is consumed this cycle.
    assign enq_ready = n_rst & (count != CNT_W'(DEPTH));
    assign deq_valid = n_rst & (count != '0);
    assign enq_fire  = enq_valid & enq_ready & ~flush;
    assign deq_fire  = deq_valid & deq_ready & ~flush;

    assign {deq_pc, deq_instr} = storage[rd_ptr];

    always_ff @(posedge clk) begin
        if (!n_rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else if (flush) begin
            rd_ptr <= wr_ptr;
            count  <= '0;
        end else begin
            if (enq_fire) begin
                wr_ptr <= wr_ptr + PTR_W'(1);
            end
            if (deq_fire) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
            end
            case ({enq_fire, deq_fire})
                2'b10:   count <= count + CNT_W'(1);
                2'b01:   count <= count - CNT_W'(1);
                default: count <= count;
            endcase
        end
    end

    // Storage is deliberately left unreset; enq_fire already excludes reset and flush.
    always_ff @(posedge clk) begin
        if (enq_fire) begin
            storage[wr_ptr] <= {enq_pc, enq_instr};
        end
    end

endmodule
